// File: rtl/sched_pkg.sv
// Shared types and defaults for the instance round-robin scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } sched_state_e;

    localparam int SCHED_NUM_REQ_DEF = 5;

endpackage : sched_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// searching upward and wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import sched_pkg::*;
#(
    parameter int NUM_REQ = SCHED_NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      enc;
    logic [IW:0]        sum;

    always_comb begin
        // Rotate so that ptr_i lands on bit 0, then the lowest set bit wins.
        rot = NUM_REQ'({req_i, req_i} >> ptr_i);
        enc = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                enc = IW'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, enc};
        if (sum >= (IW+1)'(NUM_REQ)) begin
            sum = sum - (IW+1)'(NUM_REQ);
        end
        idx_o = sum[IW-1:0];
        any_o = |req_i;
    end

endmodule : rr_pick

// File: rtl/inst_rr_scheduler.sv
// Round-robin scheduler sharing one resource among NUM_REQ leaf instances.
// Optional forced release after MAX_HOLD grant cycles when SCHED_TIMEOUT_EN is defined.
module inst_rr_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ  = SCHED_NUM_REQ_DEF,
    parameter int MAX_HOLD = 200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MAX_HOLD < 2) begin : g_bad_params
        $error("inst_rr_scheduler: NUM_REQ and MAX_HOLD must both be >= 2");
    end

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      gnt_id_q, gnt_id_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               pick_any;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               release_now;
    logic               hold_expired;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_idx == IW'(gi));
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int HOLD_BITS = $clog2(MAX_HOLD);
    localparam int CW = (HOLD_BITS < 8) ? 8 : ((HOLD_BITS > 16) ? 16 : HOLD_BITS);

    logic [CW-1:0] hold_q, hold_d;

    // Held at zero outside GRANT so every grant starts counting from 0.
    always_comb begin
        hold_d = '0;
        if (state_q == S_GRANT) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_expired = (state_q == S_GRANT) && (hold_q == CW'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    assign release_now = done_i[gnt_id_q] || !req_i[gnt_id_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d  = S_GRANT;
                    gnt_d    = pick_onehot;
                    gnt_id_d = pick_idx;
                    busy_d   = 1'b1;
                end
            end
            S_GRANT: begin
                // A done coinciding with expiry counts as a normal completion.
                if (release_now || hold_expired) begin
                    state_d   = S_RELEASE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = !release_now;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                ptr_d   = (gnt_id_q == IW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule : inst_rr_scheduler

// File: tb/tb_inst_rr_scheduler.sv
// Scoreboard bench for inst_rr_scheduler; adapts to SCHED_TIMEOUT_EN.
module tb_inst_rr_scheduler;

    localparam int N = 5;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_i;
    logic [N-1:0] done_i;
    logic [N-1:0] gnt_o;
    logic [2:0]   gnt_id_o;
    logic         busy_o;
    logic         timeout_o;

    int vectors = 0;
    int fails   = 0;
    int exp_q[$];
    int tmo_exp = 0;

`ifdef SCHED_TIMEOUT_EN
    inst_rr_scheduler #(.NUM_REQ(N), .MAX_HOLD(8)) dut (
`else
    inst_rr_scheduler #(.NUM_REQ(N)) dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!busy_o) begin
            vectors++;
            fails++;
            $display("FAIL %s: no grant within 20 cycles, got busy=0 expected 1", name);
        end
    endtask

    task automatic pulse_done(input int id);
        done_i[id] = 1'b1;
        @(negedge clk);
        done_i = '0;
    endtask

    // Monitor: every new grant (busy rising) and every timeout pulse is scored.
    logic busy_prev = 1'b0;
    logic tmo_prev  = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            busy_prev = 1'b0;
            tmo_prev  = 1'b0;
        end else begin
            if (busy_o && !busy_prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL grant: unexpected grant gnt=%05b id=%0d", gnt_o, gnt_id_o);
                end else begin
                    int e;
                    logic [N-1:0] eg;
                    e  = exp_q.pop_front();
                    eg = N'(1) << e;
                    if (gnt_o !== eg || gnt_id_o !== 3'(e)) begin
                        fails++;
                        $display("FAIL grant: got gnt=%05b id=%0d expected gnt=%05b id=%0d",
                                 gnt_o, gnt_id_o, eg, e);
                    end else begin
                        $display("ok   grant: gnt=%05b id=%0d", gnt_o, gnt_id_o);
                    end
                end
            end
            if (timeout_o && !tmo_prev) begin
                vectors++;
                if (tmo_exp == 0) begin
                    fails++;
                    $display("FAIL timeout: got unexpected pulse expected none");
                end else begin
                    tmo_exp--;
                    $display("ok   timeout: pulse seen");
                end
            end
            busy_prev = busy_o;
            tmo_prev  = timeout_o;
        end
    end

    initial begin
        int cnt;
        req_i  = '0;
        done_i = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state with all requests asserted
        req_i = 5'b11111;
        @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_gnt_id", 32'(gnt_id_o), 0);
        exp_q.push_back(0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_latency", 32'(gnt_o), 32'b00001);
        @(negedge clk);

        // Rotation 0,1,2,3,4,0
        for (int k = 0; k < 5; k++) begin
            wait_busy("rotate");
            exp_q.push_back((k + 1) % 5);
            pulse_done(k);
            check("rot_gap", 32'(gnt_o), 0);
        end
        wait_busy("rotate_last");

        // Grantee 0 drops; 3 wins; then drop 3 with ptr=4 and req=00110 -> 1, then 2
        req_i = 5'b01000;
        exp_q.push_back(3);
        @(negedge clk);
        wait_busy("to3");
        req_i = 5'b00110;
        exp_q.push_back(1);
        @(negedge clk);
        wait_busy("wrap");
        check("wrap_skip", 32'(gnt_o), 32'b00010);
        exp_q.push_back(2);
        pulse_done(1);
        wait_busy("after_wrap");
        check("skip_next", 32'(gnt_o), 32'b00100);

        // done on a non-granted line is ignored; dropping req releases
        req_i = 5'b01100;
        pulse_done(3);
        check("done3_ignored", 32'(gnt_o), 32'b00100);
        check("done3_busy", 32'(busy_o), 1);
        req_i = 5'b01000;
        exp_q.push_back(3);
        @(posedge clk);
        #1 check("drop_release", 32'(busy_o), 0);
        @(negedge clk);

        // Asynchronous reset while gnt=01000; ptr restarts at 0
        wait_busy("pre_reset");
        req_i = 5'b11001;
        @(negedge clk);
        check("hold_3", 32'(gnt_o), 32'b01000);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt_o), 0);
        check("async_rst_busy", 32'(busy_o), 0);
        exp_q.push_back(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_busy("post_reset");
        check("rst_ptr0", 32'(gnt_o), 32'b00001);

        // Holder never signals done
        cnt = 0;
`ifdef SCHED_TIMEOUT_EN
        exp_q.push_back(3);
        tmo_exp++;
        while (busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("hold_cycles", 32'(cnt), 8);
        check("tmo_high", 32'(timeout_o), 1);
        @(negedge clk);
        check("tmo_width", 32'(timeout_o), 0);
        wait_busy("after_tmo");
        check("after_tmo_gnt", 32'(gnt_o), 32'b01000);
`else
        while (busy_o && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("hold_cycles", 32'(cnt), 1000);
        check("hold_busy", 32'(busy_o), 1);
        check("hold_no_tmo", 32'(timeout_o), 0);
        exp_q.push_back(3);
        req_i = 5'b11000;
        @(negedge clk);
        wait_busy("after_hold");
        check("after_hold_gnt", 32'(gnt_o), 32'b01000);
`endif
        req_i = '0;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy_o), 0);
        check("sb_empty", 32'(exp_q.size()), 0);
        check("tmo_consumed", 32'(tmo_exp), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_inst_rr_scheduler
